lsu_mem_port: RTL
=================

# lsu_mem_port

Load/store responder that executes the memory operations requested by the core's control unit. Accepts one load or store per handshake, qualified by the access size/sign code (funct3 from `op_PMEM[2:0]`). Drives a word-addressed data-memory port with byte masks and returns aligned, sign- or zero-extended load data. Sits between the core datapath (ALU result as address, rs2 as store data) and the data memory / bus bridge.

## Interface
- `TIMEOUT_CYC`, 255: max cycles waiting on `mem_ready` or `mem_rvalid` before aborting with error; 8-bit counter, minimum value 1.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: core presents a memory operation.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_load` in 1: operation is a load.
- `req_store` in 1: operation is a store; `req_load` and `req_store` both high, or both low, with `req_valid` is illegal (error).
- `req_funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU illegal for stores; 011/110/111 always illegal.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-justified.
- `rsp_valid` out 1: one-cycle pulse, operation complete.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: qualified by `rsp_valid`; illegal op, misalignment (see Configuration), or timeout.
- `mem_valid` out 1: memory request.
- `mem_ready` in 1: memory accepts request this cycle.
- `mem_we` out 1: request is a write.
- `mem_addr` out 32: `{req_addr[31:2], 2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wmask` out 4: byte enables; 0 on reads.
- `mem_rvalid` in 1: read data valid, any cycle after read acceptance.
- `mem_rdata` in 32: read word.

## Operation
- States: IDLE, ISSUE, WAIT_R, RESP.
- IDLE: `req_ready`=1. On `req_valid`: register addr, funct3, load/store, wdata. Illegal op → RESP with err. Otherwise → ISSUE.
- ISSUE: `mem_valid`=1, address/data/mask stable until `mem_ready`. On `mem_ready`: store → RESP; load → WAIT_R.
- WAIT_R: on `mem_rvalid` capture extended data → RESP.
- RESP: `rsp_valid`=1 for exactly one cycle → IDLE.
- Timeout: counter cleared on entering ISSUE and on entering WAIT_R, increments each cycle in those states; reaching `TIMEOUT_CYC` → RESP with err, `mem_valid` dropped. A late `mem_rvalid` in IDLE is ignored.
- Write lanes, with o = addr[1:0]:
  - B: data `{4{wdata[7:0]}}`, mask `4'b0001 << o`.
  - H: data `{2{wdata[15:0]}}`, mask `4'b0011 << {o[1],1'b0}`.
  - W: data wdata, mask 1111.
- Read: byte = `mem_rdata[8*o +: 8]`, half = `mem_rdata[16*o[1] +: 16]`; B/H sign-extend, BU/HU zero-extend, W passes through.
- `mem_rvalid` in states other than WAIT_R is ignored.

## Timing
- Reset values: `req_ready`=0 during reset, 1 the cycle after; `rsp_valid`, `rsp_err`, `mem_valid`, `mem_we` = 0; `rsp_rdata`, `mem_addr`, `mem_wdata`, `mem_wmask` = 0. State → IDLE.
- Minimum latencies, with acceptance at cycle T:
  - Load: `mem_valid` at T+1; with `mem_ready` at T+1 and `mem_rvalid` at T+2, `rsp_valid` at T+3.
  - Store: `rsp_valid` at T+2 if `mem_ready` at T+1.
  - Illegal op: `rsp_valid` at T+1, no memory request.
- `mem_rvalid` in the same cycle as `mem_ready` is not accepted; read data is taken in WAIT_R only.
- Reset asserted mid-transaction: aborts immediately. No `rsp_valid` is issued; a pending memory response is dropped.
- All outputs are registered.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: H/HU with addr[0]=1, or W with addr[1:0]≠0, is an error. Response at T+1 with `rsp_err`=1, no memory request.
- `LSU_MISALIGN_CHECK_EN` undefined: misaligned accesses proceed.
  - H uses lane addr[1] and ignores addr[0].
  - W ignores addr[1:0].
  - No error is raised.

## Test plan
- SB: addr 0x8000_0003, wdata 0x1234_56AB → `mem_addr` 0x8000_0000, `mem_wdata` 0xABAB_ABAB, `mem_wmask` 1000, `rsp_valid` at T+2, `rsp_err`=0.
- LB/LBU: addr 0x8000_0002, `mem_rdata` 0x11F0_2233 → LB `rsp_rdata` 0xFFFF_FFF0; LBU `rsp_rdata` 0x0000_00F0.
- LH: addr 0x8000_0002, `mem_rdata` 0x8001_0000 → 0xFFFF_8001. LW with `mem_ready` held low 3 cycles → `rsp_valid` delayed 3 cycles, address stable throughout.
- LW addr 0x8000_0001:
  - With `LSU_MISALIGN_CHECK_EN`: `rsp_err`=1 at T+1, `mem_valid` never rises.
  - Without the macro: `mem_addr` 0x8000_0000, normal response.
- Illegal ops → `rsp_err`=1 at T+1, no memory request:
  - funct3=110 load.
  - funct3=100 store.
  - `req_load` and `req_store` both high.
- `TIMEOUT_CYC`=4, `mem_rvalid` never asserted → `rsp_err`=1 after 4 WAIT_R cycles. A later `mem_rvalid` is ignored. Reset during ISSUE → `mem_valid`=0 the next cycle and no `rsp_valid`.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store responder: one load or store per handshake, word-addressed memory port with byte lanes.
// Optional misalignment trapping when LSU_MISALIGN_CHECK_EN is defined.
module lsu_mem_port #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          op_load;
    logic [2:0]    op_f3;
    logic [1:0]    op_off;

    logic          accept;
    logic          misalign;
    logic          illegal;
    logic          timeout;
    logic [DW-1:0] lane_wdata;
    logic [3:0]    lane_wmask;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [DW-1:0] rd_ext;
    logic          rsp_err_nxt;
    logic [DW-1:0] rsp_rdata_nxt;

    assign accept  = req_valid && req_ready;
    assign timeout = (cnt == TO_LAST);

    // Request legality: exclusive load/store, known size code, no unsigned stores.
    always_comb begin
        misalign = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        illegal = (req_load == req_store)
               || (req_funct3[1:0] == 2'b11)
               || (req_funct3 == 3'b110)
               || (req_store && req_funct3[2])
               || misalign;
    end

    // Store lane replication and byte enables.
    always_comb begin
        lane_wdata = req_wdata;
        lane_wmask = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                lane_wdata = {4{req_wdata[7:0]}};
                lane_wmask = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{req_wdata[15:0]}};
                lane_wmask = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
                lane_wdata = req_wdata;
                lane_wmask = 4'b1111;
            end
        endcase
    end

    // Load lane extraction and extension.
    always_comb begin
        case (op_off)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = op_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_f3)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  rd_ext = {24'd0, rd_byte};
            3'b101:  rd_ext = {16'd0, rd_half};
            default: rd_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        state_nxt   = S_RESP;
                        rsp_err_nxt = 1'b1;
                    end else begin
                        state_nxt = S_ISSUE;
                        cnt_nxt   = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    state_nxt = op_load ? S_WAIT_R : S_RESP;
                    cnt_nxt   = '0;
                end else if (timeout) begin
                    state_nxt   = S_RESP;
                    rsp_err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAIT_R: begin
                if (mem_rvalid) begin
                    state_nxt     = S_RESP;
                    rsp_rdata_nxt = rd_ext;
                end else if (timeout) begin
                    state_nxt   = S_RESP;
                    rsp_err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered outputs; request fields are latched once per legal acceptance and held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            op_load   <= 1'b0;
            op_f3     <= '0;
            op_off    <= '0;
        end else begin
            req_ready <= (state_nxt == S_IDLE);
            rsp_valid <= (state_nxt == S_RESP);
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            mem_valid <= (state_nxt == S_ISSUE);
            if (accept && !illegal) begin
                op_load   <= req_load;
                op_f3     <= req_funct3;
                op_off    <= req_addr[1:0];
                mem_we    <= req_store;
                mem_addr  <= {req_addr[31:2], 2'b00};
                mem_wdata <= lane_wdata;
                mem_wmask <= req_store ? lane_wmask : 4'b0000;
            end
        end
    end

endmodule
